// File: rtl/qspi_flash_responder.sv
// QSPI flash emulator: decodes mode-0 READ/FAST READ/QUAD OUT/READ ID commands
// and streams bytes from an external byte-wide store, all in the clk_i domain.
module qspi_flash_responder #(
   parameter int          ADDR_W    = 24,
   parameter int          DUMMY_CYC = 8,
   parameter logic [23:0] JEDEC_ID  = 24'hEF4018
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              qspi_sclk_i,
   input  logic              qspi_cs_ni,
   input  logic [3:0]        qspi_data_i,
   output logic [3:0]        qspi_data_o,
   output logic [3:0]        qspi_data_oen_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              busy_o,
   output logic              bad_cmd_o
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
   localparam logic [2:0] ST_DUMMY  = 3'd3;
   localparam logic [2:0] ST_DATA   = 3'd4;
   localparam logic [2:0] ST_ID     = 3'd5;
   localparam logic [2:0] ST_IGNORE = 3'd6;
   localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYC - 1);

   logic [2:0]        sclk_sync_q, sclk_sync_d;
   logic [2:0]        cs_sync_q, cs_sync_d;
   logic [1:0]        io0_sync_q, io0_sync_d;
   logic [2:0]        state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [22:0]       sr_q, sr_d;
   logic              quad_q, quad_d;
   logic              dummy_en_q, dummy_en_d;
   logic [7:0]        cur_q, cur_d;
   logic [3:0]        bits_left_q, bits_left_d;
   logic [7:0]        nxt_q, nxt_d;
   logic              rd_pend_q, rd_pend_d;
   logic [1:0]        id_idx_q, id_idx_d;
   logic [3:0]        data_q, data_d;
   logic [3:0]        oen_q, oen_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              busy_q, busy_d;
   logic              bad_cmd_q, bad_cmd_d;

   logic              sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
   logic [23:0]       sr_shift_s;
   logic [7:0]        out_byte_s;
   logic              io_unused_s;

   assign io_unused_s = &{1'b0, qspi_data_i[3:1]};

   function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return JEDEC_ID[23:16];
         2'd1:    return JEDEC_ID[15:8];
         default: return JEDEC_ID[7:0];
      endcase
   endfunction

   assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
   assign sr_shift_s  = {sr_q, io0_sync_q[1]};

   // Next-state logic: synchronisers, command decode and byte pipeline
   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], qspi_sclk_i};
      cs_sync_d   = {cs_sync_q[1:0], qspi_cs_ni};
      io0_sync_d  = {io0_sync_q[0], qspi_data_i[0]};
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      quad_d      = quad_q;
      dummy_en_d  = dummy_en_q;
      cur_d       = cur_q;
      bits_left_d = bits_left_q;
      id_idx_d    = id_idx_q;
      data_d      = data_q;
      oen_d       = oen_q;
      mem_req_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      busy_d      = ~cs_sync_q[1];
      bad_cmd_d   = 1'b0;
      rd_pend_d   = mem_req_q;
      if (rd_pend_q) nxt_d = mem_rdata_i;
      else           nxt_d = nxt_q;
      if (bits_left_q != 4'd0)    out_byte_s = cur_q;
      else if (state_q == ST_ID)  out_byte_s = jedec_byte(id_idx_q);
      else                        out_byte_s = nxt_q;

      // CS_n release beats any SCLK edge in the same cycle and drops in-flight reads
      if (cs_rise_s) begin
         state_d     = ST_IDLE;
         cnt_d       = 5'd0;
         bits_left_d = 4'd0;
         id_idx_d    = 2'd0;
         data_d      = 4'h0;
         oen_d       = 4'hF;
         rd_pend_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall_s) begin
                  state_d = ST_CMD;
                  cnt_d   = 5'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CMD: begin
               if (sclk_rise_s) begin
                  sr_d  = sr_shift_s[22:0];
                  cnt_d = cnt_q + 5'd1;
                  if (cnt_q == 5'd7) begin
                     cnt_d       = 5'd0;
                     bits_left_d = 4'd0;
                     case (sr_shift_s[7:0])
                        8'h03: begin state_d = ST_ADDR; quad_d = 1'b0; dummy_en_d = 1'b0; end
                        8'h0B: begin state_d = ST_ADDR; quad_d = 1'b0; dummy_en_d = 1'b1; end
                        8'h6B: begin state_d = ST_ADDR; quad_d = 1'b1; dummy_en_d = 1'b1; end
                        8'h9F: begin state_d = ST_ID;   quad_d = 1'b0; id_idx_d = 2'd0; end
                        default: begin state_d = ST_IGNORE; bad_cmd_d = 1'b1; end
                     endcase
                  end else begin
                     state_d = ST_CMD;
                  end
               end else begin
                  state_d = ST_CMD;
               end
            end
            ST_ADDR: begin
               if (sclk_rise_s) begin
                  sr_d  = sr_shift_s[22:0];
                  cnt_d = cnt_q + 5'd1;
                  if (cnt_q == 5'd23) begin
                     cnt_d      = 5'd0;
                     mem_addr_d = sr_shift_s[ADDR_W-1:0];
                     mem_req_d  = 1'b1;
                     if (dummy_en_q && (DUMMY_CYC != 0)) state_d = ST_DUMMY;
                     else                                 state_d = ST_DATA;
                  end else begin
                     state_d = ST_ADDR;
                  end
               end else begin
                  state_d = ST_ADDR;
               end
            end
            ST_DUMMY: begin
               if (sclk_rise_s && (cnt_q == DUMMY_LAST)) begin
                  state_d = ST_DATA;
                  cnt_d   = 5'd0;
               end else if (sclk_rise_s) begin
                  cnt_d = cnt_q + 5'd1;
               end else begin
                  cnt_d = cnt_q;
               end
            end
            ST_DATA, ST_ID: begin
               if (sclk_fall_s) begin
                  if (quad_q) begin
                     data_d      = out_byte_s[7:4];
                     cur_d       = {out_byte_s[3:0], 4'h0};
                     oen_d       = 4'b0000;
                     bits_left_d = (bits_left_q == 4'd0) ? 4'd4 : bits_left_q - 4'd4;
                  end else begin
                     data_d      = {2'b00, out_byte_s[7], 1'b0};
                     cur_d       = {out_byte_s[6:0], 1'b0};
                     oen_d       = 4'b1101;
                     bits_left_d = (bits_left_q == 4'd0) ? 4'd7 : bits_left_q - 4'd1;
                  end
                  // Loading a fresh byte triggers the prefetch of the following one
                  if (bits_left_q == 4'd0 && state_q == ST_DATA) begin
                     mem_req_d  = 1'b1;
                     mem_addr_d = mem_addr_q + ADDR_W'(1);
                  end else if (bits_left_q == 4'd0) begin
                     id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                  end else begin
                     id_idx_d = id_idx_q;
                  end
               end else begin
                  data_d = data_q;
               end
            end
            ST_IGNORE: state_d = ST_IGNORE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sclk_sync_q <= 3'b000;
         cs_sync_q   <= 3'b111;
         io0_sync_q  <= 2'b00;
         state_q     <= ST_IDLE;
         cnt_q       <= 5'd0;
         sr_q        <= 23'd0;
         quad_q      <= 1'b0;
         dummy_en_q  <= 1'b0;
         cur_q       <= 8'h00;
         bits_left_q <= 4'd0;
         nxt_q       <= 8'h00;
         rd_pend_q   <= 1'b0;
         id_idx_q    <= 2'd0;
         data_q      <= 4'h0;
         oen_q       <= 4'hF;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         busy_q      <= 1'b0;
         bad_cmd_q   <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         io0_sync_q  <= io0_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         quad_q      <= quad_d;
         dummy_en_q  <= dummy_en_d;
         cur_q       <= cur_d;
         bits_left_q <= bits_left_d;
         nxt_q       <= nxt_d;
         rd_pend_q   <= rd_pend_d;
         id_idx_q    <= id_idx_d;
         data_q      <= data_d;
         oen_q       <= oen_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         busy_q      <= busy_d;
         bad_cmd_q   <= bad_cmd_d;
      end
   end

   assign qspi_data_o     = data_q;
   assign qspi_data_oen_o = oen_q;
   assign mem_req_o       = mem_req_q;
   assign mem_addr_o      = mem_addr_q;
   assign busy_o          = busy_q;
   assign bad_cmd_o       = bad_cmd_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench: plays the QSPI master and a byte-wide backing store.
module tb_qspi_flash_responder;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        qspi_sclk_i;
   logic        qspi_cs_ni;
   logic [3:0]  qspi_data_i;
   logic [3:0]  qspi_data_o;
   logic [3:0]  qspi_data_oen_o;
   logic        mem_req_o;
   logic [23:0] mem_addr_o;
   logic [7:0]  mem_rdata_i = 8'hEE;
   logic        busy_o;
   logic        bad_cmd_o;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          bad_cnt = 0;
   int          proto_err = 0;
   logic        prev_req = 1'b0;
   logic [23:0] req_addrs[$];

   logic [3:0]  dout, doen;
   logic [71:0] rx;
   int          base, bad0;
   logic        oen_flag;

   qspi_flash_responder #(.ADDR_W(24), .DUMMY_CYC(8), .JEDEC_ID(24'hEF4018)) dut (
      .clk_i(clk), .reset_i(reset_i), .qspi_sclk_i(qspi_sclk_i), .qspi_cs_ni(qspi_cs_ni),
      .qspi_data_i(qspi_data_i), .qspi_data_o(qspi_data_o), .qspi_data_oen_o(qspi_data_oen_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .bad_cmd_o(bad_cmd_o));

   always #5 clk = ~clk;

   function automatic logic [7:0] store_f(input logic [23:0] a);
      case (a)
         24'h000010: return 8'hA5;
         24'h000011: return 8'h3C;
         24'hFFFFFF: return 8'h12;
         24'h000000: return 8'h34;
         24'h000020: return 8'h5A;
         default:    return a[7:0] ^ 8'h55;
      endcase
   endfunction

   // Backing store with one-cycle read latency, plus request protocol monitor
   always @(posedge clk) begin
      if (mem_req_o) begin
         req_addrs.push_back(mem_addr_o);
         if (prev_req || qspi_cs_ni) proto_err <= proto_err + 1;
      end
      if (bad_cmd_o) bad_cnt <= bad_cnt + 1;
      prev_req    <= mem_req_o;
      mem_rdata_i <= mem_req_o ? store_f(mem_addr_o) : 8'hEE;
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One SCLK period: drive IO, rise, fall, then sample after the DUT has reacted
   task automatic sclk_cycle(input logic [3:0] din, output logic [3:0] o, output logic [3:0] e);
      qspi_data_i = din;
      #40 qspi_sclk_i = 1'b1;
      #80 qspi_sclk_i = 1'b0;
      #80;
      o = qspi_data_o;
      e = qspi_data_oen_o;
   endtask

   task automatic send_bits(input logic [23:0] bits, input int n, output logic [3:0] o, output logic [3:0] e);
      for (int i = n - 1; i >= 0; i--) sclk_cycle({3'b000, bits[i]}, o, e);
   endtask

   task automatic cs_low();
      qspi_cs_ni = 1'b0;
      #100;
   endtask

   task automatic cs_high();
      qspi_cs_ni = 1'b1;
      #100;
   endtask

   initial begin
      reset_i = 1'b1; qspi_sclk_i = 1'b0; qspi_cs_ni = 1'b1; qspi_data_i = 4'h0;
      #20;
      check("rst_oen", 72'(qspi_data_oen_o), 72'hF);
      check("rst_data", 72'(qspi_data_o), 72'h0);
      check("rst_req", 72'(mem_req_o), 72'h0);
      check("rst_addr", 72'(mem_addr_o), 72'h0);
      check("rst_busy", 72'(busy_o), 72'h0);
      check("rst_bad", 72'(bad_cmd_o), 72'h0);
      #10 reset_i = 1'b0;
      #50;

      // 03 READ at 0x10, two bytes on IO1
      cs_low();
      check("busy_low", 72'(busy_o), 72'h1);
      base = req_addrs.size();
      send_bits(24'h03, 8, dout, doen);
      check("cmd_oen", 72'(doen), 72'hF);
      send_bits(24'h000010, 24, dout, doen);
      rx = 72'(dout[1]);
      for (int i = 0; i < 15; i++) begin
         sclk_cycle(4'h0, dout, doen);
         rx = {rx[70:0], dout[1]};
      end
      check("rd_bits", rx, 72'hA53C);
      check("rd_oen", 72'(doen), 72'hD);
      check("rd_nreq", 72'(req_addrs.size() - base), 72'd3);
      check("rd_a0", 72'(req_addrs[base]), 72'h10);
      check("rd_a1", 72'(req_addrs[base + 1]), 72'h11);
      check("rd_a2", 72'(req_addrs[base + 2]), 72'h12);
      cs_high();
      check("rd_end_oen", 72'(qspi_data_oen_o), 72'hF);
      check("rd_end_busy", 72'(busy_o), 72'h0);

      // 6B QUAD OUT at 0xFFFFFF with wrap to 0
      cs_low();
      base = req_addrs.size();
      send_bits(24'h6B, 8, dout, doen);
      send_bits(24'hFFFFFF, 24, dout, doen);
      check("q_addr_oen", 72'(doen), 72'hF);
      send_bits(24'h0, 7, dout, doen);
      check("q_dummy7_oen", 72'(doen), 72'hF);
      sclk_cycle(4'h0, dout, doen);
      check("q_dummy8_oen", 72'(doen), 72'h0);
      rx = 72'(dout);
      for (int i = 0; i < 3; i++) begin
         sclk_cycle(4'h0, dout, doen);
         rx = {rx[67:0], dout};
      end
      check("q_nibbles", rx, 72'h1234);
      check("q_nreq", 72'(req_addrs.size() - base), 72'd3);
      check("q_a0", 72'(req_addrs[base]), 72'hFFFFFF);
      check("q_wrap", 72'(req_addrs[base + 1]), 72'h000000);
      check("q_a2", 72'(req_addrs[base + 2]), 72'h000001);
      cs_high();

      // 9F READ ID, nine bytes
      cs_low();
      base = req_addrs.size();
      send_bits(24'h9F, 8, dout, doen);
      rx = 72'(dout[1]);
      for (int i = 0; i < 71; i++) begin
         sclk_cycle(4'h0, dout, doen);
         rx = {rx[70:0], dout[1]};
      end
      check("id_bytes", rx, 72'hEF4018EF4018EF4018);
      check("id_oen", 72'(doen), 72'hD);
      check("id_noreq", 72'(req_addrs.size() - base), 72'd0);
      cs_high();

      // Unsupported opcode 05
      cs_low();
      base = req_addrs.size();
      bad0 = bad_cnt;
      send_bits(24'h05, 8, dout, doen);
      check("bad_pulse", 72'(bad_cnt - bad0), 72'd1);
      oen_flag = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sclk_cycle(4'hF, dout, doen);
         if (doen != 4'hF) oen_flag = 1'b1;
      end
      check("bad_oen_held", 72'(oen_flag), 72'h0);
      check("bad_once", 72'(bad_cnt - bad0), 72'd1);
      check("bad_noreq", 72'(req_addrs.size() - base), 72'd0);
      cs_high();
      cs_low();
      send_bits(24'h03, 8, dout, doen);
      send_bits(24'h000011, 24, dout, doen);
      rx = 72'(dout[1]);
      for (int i = 0; i < 7; i++) begin
         sclk_cycle(4'h0, dout, doen);
         rx = {rx[70:0], dout[1]};
      end
      check("after_bad_rd", rx, 72'h3C);
      cs_high();

      // Abort 0B mid-address, then a clean 03 at 0x20
      cs_low();
      send_bits(24'h0B, 8, dout, doen);
      send_bits(24'h001555, 13, dout, doen);
      cs_high();
      check("abort_oen", 72'(qspi_data_oen_o), 72'hF);
      check("abort_busy", 72'(busy_o), 72'h0);
      cs_low();
      base = req_addrs.size();
      send_bits(24'h03, 8, dout, doen);
      send_bits(24'h000020, 24, dout, doen);
      rx = 72'(dout[1]);
      for (int i = 0; i < 7; i++) begin
         sclk_cycle(4'h0, dout, doen);
         rx = {rx[70:0], dout[1]};
      end
      check("abort_rd", rx, 72'h5A);
      check("abort_a0", 72'(req_addrs[base]), 72'h20);
      cs_high();

      // Asynchronous reset while quad data is being driven
      cs_low();
      send_bits(24'h6B, 8, dout, doen);
      send_bits(24'h000000, 24, dout, doen);
      send_bits(24'h0, 8, dout, doen);
      check("q2_drive_oen", 72'(doen), 72'h0);
      check("q2_nibble", 72'(dout), 72'h3);
      #3 reset_i = 1'b1;
      #1;
      check("arst_oen", 72'(qspi_data_oen_o), 72'hF);
      check("arst_data", 72'(qspi_data_o), 72'h0);
      #26 reset_i = 1'b0;
      #1;
      check("arst_rel_oen", 72'(qspi_data_oen_o), 72'hF);
      check("arst_rel_busy", 72'(busy_o), 72'h0);
      #9;
      cs_high();
      cs_low();
      send_bits(24'h9F, 8, dout, doen);
      rx = 72'(dout[1]);
      for (int i = 0; i < 7; i++) begin
         sclk_cycle(4'h0, dout, doen);
         rx = {rx[70:0], dout[1]};
      end
      check("post_rst_id", rx, 72'hEF);
      cs_high();

      check("req_protocol", 72'(proto_err), 72'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
